// File: rtl/regfile_bypass.sv
// regfile_bypass -- parametrised register bank.
//
// NREGS words of XLEN bits. The bank has two combinational read ports and one
// synchronous write port. Register 0 always reads as zero and has no storage.
// Register SP_IDX resets to SP_INIT. When BYPASS is set, a read of the
// register being written returns the incoming write data in the same cycle.
//
// Ports:
//   clk        in   1     rising-edge clock
//   reset      in   1     asynchronous, active-high reset
//   we         in   1     write enable
//   rs1, rs2   in   AW    read addresses
//   rd         in   AW    write address
//   wd         in   XLEN  write data
//   rd1, rd2   out  XLEN  combinational read data
//   wr_commit  out  1     registered pulse: a write to a non-zero register
//                         took effect on the last edge
module regfile_bypass #(
   parameter  int unsigned          XLEN    = 32,
   parameter  int unsigned          NREGS   = 32,
   localparam int unsigned          AW      = $clog2(NREGS),
   parameter  int unsigned          BYPASS  = 1,
   parameter  int unsigned          SP_IDX  = 2,
   parameter  logic [31:0]          SP_INIT = 32'h0000_0FFC
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            wr_commit
);

   localparam logic [XLEN-1:0] SP_RESET = XLEN'(SP_INIT);

   // Register 0 is elided from storage.
   logic [XLEN-1:0] r_mem [1:NREGS-1];
   logic            r_wr_commit;

   logic            w_wr_ok;
   logic            w_byp1;
   logic            w_byp2;

   assign w_wr_ok = we && (rd != '0);

   // Bypass is masked while reset is held so the ports show reset contents.
   assign w_byp1 = (BYPASS != 0) && !reset && w_wr_ok && (rd == rs1);
   assign w_byp2 = (BYPASS != 0) && !reset && w_wr_ok && (rd == rs2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // SP_IDX == 0 never matches since the loop starts at 1.
         for (int unsigned i = 1; i < NREGS; i++) begin
            r_mem[AW'(i)] <= (i == SP_IDX) ? SP_RESET : '0;
         end
         r_wr_commit <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_mem[rd] <= wd;
         end
         r_wr_commit <= w_wr_ok;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (rs1 != '0) begin
         rd1 = w_byp1 ? wd : r_mem[rs1];
      end
      if (rs2 != '0) begin
         rd2 = w_byp2 ? wd : r_mem[rs2];
      end
   end

   assign wr_commit = r_wr_commit;

endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass -- directed bench for regfile_bypass.
//
// Three instances: a (default, BYPASS=1), b (BYPASS=0, same stimulus as a),
// and s (XLEN=8, NREGS=16, SP_IDX=0). Expected values are queued when
// stimulus is driven and popped/compared when outputs are sampled.
module tb_regfile_bypass;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] wd;
   logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
   logic        a_wc, b_wc;

   logic        s_we;
   logic [3:0]  s_rs1, s_rs2, s_rd;
   logic [7:0]  s_wd;
   logic [7:0]  s_rd1, s_rd2;
   logic        s_wc;

   regfile_bypass #(.XLEN(32), .NREGS(32), .BYPASS(1), .SP_IDX(2),
                    .SP_INIT(32'h0000_0FFC)) dut_a (
      .clk(clk), .reset(rst), .we(we), .rs1(rs1), .rs2(rs2), .rd(rd),
      .wd(wd), .rd1(a_rd1), .rd2(a_rd2), .wr_commit(a_wc));

   regfile_bypass #(.XLEN(32), .NREGS(32), .BYPASS(0), .SP_IDX(2),
                    .SP_INIT(32'h0000_0FFC)) dut_b (
      .clk(clk), .reset(rst), .we(we), .rs1(rs1), .rs2(rs2), .rd(rd),
      .wd(wd), .rd1(b_rd1), .rd2(b_rd2), .wr_commit(b_wc));

   regfile_bypass #(.XLEN(8), .NREGS(16), .BYPASS(1), .SP_IDX(0),
                    .SP_INIT(32'h0000_0FFC)) dut_s (
      .clk(clk), .reset(rst), .we(s_we), .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd),
      .wd(s_wd), .rd1(s_rd1), .rd2(s_rd2), .wr_commit(s_wc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam int A1 = 0, A2 = 1, AW = 2, B1 = 3, B2 = 4, BW = 5,
                  S1 = 6, S2 = 7, SW = 8;

   function automatic logic [31:0] get_obs(input int sel);
      case (sel)
         A1:      return a_rd1;
         A2:      return a_rd2;
         AW:      return {31'b0, a_wc};
         B1:      return b_rd1;
         B2:      return b_rd2;
         BW:      return {31'b0, b_wc};
         S1:      return {24'b0, s_rd1};
         S2:      return {24'b0, s_rd2};
         default: return {31'b0, s_wc};
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = get_obs(e.sel);
         n_checks++;
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; we = 1'b0; rs1 = 5'd2; rs2 = 5'd5; rd = '0; wd = '0;
      s_we = 1'b0; s_rs1 = 4'd2; s_rs2 = 4'd15; s_rd = '0; s_wd = '0;

      // Reset contents with no clock edge yet.
      #3;
      push("rst_a_x2", A1, 32'h0000_0FFC);
      push("rst_a_x5", A2, 32'h0);
      push("rst_b_x2", B1, 32'h0000_0FFC);
      push("rst_a_wc", AW, 32'h0);
      push("rst_s_x2", S1, 32'h0);
      push("rst_s_x15", S2, 32'h0);
      drain();

      // Release between edges, two idle edges.
      @(negedge clk); rst = 1'b0;
      edge_sample();
      edge_sample();
      push("idle_a_x2", A1, 32'h0000_0FFC);
      push("idle_a_wc", AW, 32'h0);
      push("idle_b_wc", BW, 32'h0);
      drain();

      // Basic write to x7.
      @(negedge clk); we = 1'b1; rd = 5'd7; wd = 32'hDEAD_BEEF; rs1 = 5'd7; rs2 = 5'd0;
      #1;
      push("wr7_pre_a_byp", A1, 32'hDEAD_BEEF);
      push("wr7_pre_b_old", B1, 32'h0);
      drain();
      edge_sample(); we = 1'b0; #1;
      push("wr7_a_rd1", A1, 32'hDEAD_BEEF);
      push("wr7_b_rd1", B1, 32'hDEAD_BEEF);
      push("wr7_a_wc1", AW, 32'h1);
      push("wr7_b_wc1", BW, 32'h1);
      drain();
      edge_sample();
      push("wr7_a_wc0", AW, 32'h0);
      push("wr7_a_hold", A1, 32'hDEAD_BEEF);
      drain();

      // Writes to x0 are discarded, no bypass on x0.
      @(negedge clk); we = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF; rs1 = 5'd0; rs2 = 5'd7;
      #1;
      push("x0_pre_a", A1, 32'h0);
      push("x0_pre_b", B1, 32'h0);
      push("x0_other_port", A2, 32'hDEAD_BEEF);
      drain();
      edge_sample(); we = 1'b0; #1;
      push("x0_post_a", A1, 32'h0);
      push("x0_a_wc", AW, 32'h0);
      push("x0_b_wc", BW, 32'h0);
      drain();

      // Bypass vs stored value on x9, both ports.
      @(negedge clk); we = 1'b1; rd = 5'd9; wd = 32'h1111_1111;
      edge_sample(); we = 1'b0;
      @(negedge clk); we = 1'b1; rd = 5'd9; wd = 32'h2222_2222; rs1 = 5'd9; rs2 = 5'd9;
      #1;
      push("byp_a_rd1", A1, 32'h2222_2222);
      push("byp_a_rd2", A2, 32'h2222_2222);
      push("nobyp_b_rd1", B1, 32'h1111_1111);
      push("nobyp_b_rd2", B2, 32'h1111_1111);
      drain();
      edge_sample(); we = 1'b0; #1;
      push("nobyp_b_post", B1, 32'h2222_2222);
      push("nobyp_b_wc", BW, 32'h1);
      drain();

      // Back-to-back fill of x1..x31 with their index.
      for (int i = 1; i < 32; i++) begin
         @(negedge clk); we = 1'b1; rd = 5'(i); wd = 32'(i);
         edge_sample();
         if (i == 16 || i == 31) push("b2b_a_wc", AW, 32'h1);
         drain();
      end
      @(negedge clk); we = 1'b0;
      for (int i = 1; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(32 - i);
         #1;
         push("fill_a_rd1", A1, 32'(i));
         push("fill_b_rd2", B2, 32'(32 - i));
         drain();
      end

      // Async reset between edges, then an edge with reset held.
      @(negedge clk); #1;
      rst = 1'b1; rs1 = 5'd2; rs2 = 5'd31;
      #1;
      push("arst_a_x2", A1, 32'h0000_0FFC);
      push("arst_a_x31", A2, 32'h0);
      push("arst_b_x2", B1, 32'h0000_0FFC);
      push("arst_a_wc", AW, 32'h0);
      drain();
      we = 1'b1; rd = 5'd3; wd = 32'd5; rs1 = 5'd3;
      #1;
      push("arst_nobyp_a", A1, 32'h0);
      drain();
      edge_sample();
      push("arst_edge_a_x3", A1, 32'h0);
      push("arst_edge_b_x3", B1, 32'h0);
      push("arst_edge_wc", AW, 32'h0);
      drain();
      @(negedge clk); rst = 1'b0; we = 1'b0;

      // Narrow instance: write x15, attempt x0.
      @(negedge clk); s_we = 1'b1; s_rd = 4'd15; s_wd = 8'hA5; s_rs1 = 4'd15; s_rs2 = 4'd0;
      edge_sample();
      push("s_x15", S1, 32'h0000_00A5);
      push("s_wc1", SW, 32'h1);
      drain();
      @(negedge clk); s_rd = 4'd0; s_wd = 8'hFF;
      #1;
      push("s_x0_pre", S2, 32'h0);
      drain();
      edge_sample(); s_we = 1'b0; #1;
      push("s_x0_post", S2, 32'h0);
      push("s_x0_wc", SW, 32'h0);
      push("s_x15_hold", S1, 32'h0000_00A5);
      drain();

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
